trinity_v5_miner: RTL and testbench
===================================

TRINITY_V5_MINER -- requirements
Module: trinity_v5_miner

Interface
REQ-001 SHALL have parameter LANES, default 4: hash lanes evaluated per cycle (power of two, 1..16).
REQ-002 SHALL have parameter NONCE_W, default 32: width of nonce and nonce_limit.
REQ-003 SHALL have parameter YIELD_W, default 32: width of mining_yield.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: depth of the found-nonce FIFO (power of two).
REQ-005 SHALL have parameter REWARD, default 1: yield increment per hit.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  begin a run; sampled only in IDLE.
REQ-009 header  in  32  block header word.
REQ-010 target  in  32  difficulty target.
REQ-011 nonce_limit  in  NONCE_W  last nonce to test, inclusive.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse in DONE.
REQ-014 found_valid / found_ready / found_nonce  out / in / NONCE_W  valid-ready FIFO read port.
REQ-015 mining_yield  out  YIELD_W  accumulated reward.
REQ-016 overflow  out  1  sticky: a hit was dropped because the FIFO was full.

Function
REQ-017 SHALL use FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: start=1 at edge S SHALL load base=0 and enter RUN. header, target and nonce_limit SHALL be latched at S.
REQ-019 RUN, each edge: SHALL capture nonces base..base+LANES-1 into stage 0, then base += LANES.
REQ-020 Lanes whose nonce > latched nonce_limit SHALL be masked invalid.
REQ-021 RUN SHALL exit to DRAIN on the issuing edge where base+LANES > nonce_limit.
REQ-022 Hash, stage 1, registered one edge after issue: h = low32((header XOR nonce) * 32'h9E3779B9), then hash = h XOR (h >> 15). All arithmetic is 32-bit.
REQ-023 A lane SHALL hit when valid and hash <= target. The hit SHALL be registered in stage 2, two edges after issue.
REQ-024 On the stage-2 edge, mining_yield SHALL add REWARD x (number of hits), saturating at all-ones.
REQ-025 On the stage-2 edge, the lowest-index hitting lane's nonce SHALL be pushed to the FIFO. Other same-cycle hits are counted in the yield but not stored.
REQ-026 A push into a full FIFO SHALL be dropped and SHALL set overflow. A pop (found_valid & found_ready) in the same cycle frees space first, so the push succeeds.
REQ-027 found_valid SHALL equal FIFO-not-empty; found_nonce SHALL be the head entry. The FIFO SHALL keep draining in every state.
REQ-028 DRAIN SHALL last exactly 2 edges, then enter DONE; DONE SHALL last 1 cycle, then IDLE.
REQ-029 start while not IDLE SHALL be ignored.
REQ-030 mining_yield and overflow SHALL persist across runs; only rst clears them.

Reset
REQ-031 rst SHALL asynchronously force IDLE, busy=0, done=0, found_valid=0, mining_yield=0, overflow=0, base=0, FIFO empty, and all pipeline valids 0.
REQ-032 rst asserted mid-run SHALL discard in-flight hits. After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Reset: assert rst at time 0 -> all outputs 0; remain 0 for 10 cycles after release with start=0.
REQ-034 Single hit (LANES=4): header=5, target=0, nonce_limit=15, found_ready=0, start at edge S -> exactly one FIFO entry, found_nonce=5; mining_yield=1; busy over S..S+6; done high for the single cycle after S+6; IDLE at S+7.
REQ-035 FIFO full/overflow: target=32'hFFFFFFFF, nonce_limit=15, found_ready=0 -> FIFO holds 0,4,8,12; mining_yield=16; overflow=0. Rerun with nonce_limit=19 -> entries unchanged; mining_yield=36; overflow=1.
REQ-036 Partial last issue: target=32'hFFFFFFFF, nonce_limit=13, found_ready=1 -> mining_yield=14; popped sequence 0,4,8,12; nonces 14 and 15 never counted.
REQ-037 Mid-run reset plus ignored start: pulse rst one cycle after S+2 -> all outputs 0; a start during the earlier RUN has no effect; a fresh start reproduces the REQ-034 result.
REQ-038 Saturation: YIELD_W=4, target=32'hFFFFFFFF, nonce_limit=31 -> mining_yield stops at 15 and does not wrap.

Source files
------------

// File: rtl/trinity_v5_miner.sv
// trinity_v5_miner: multi-lane nonce search engine.
//
// A run sweeps nonces 0..nonce_limit, LANES per cycle, through a three-stage
// pipeline: issue (stage 0), hash (stage 1), and hit/accumulate (stage 2).
// Every hit adds REWARD to a saturating yield counter. The lowest-index hit of
// each issue group is queued in a small found-nonce FIFO.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a run; only looked at while idle
//   header, target      block header word and difficulty target, latched at start
//   nonce_limit         last nonce tested (inclusive), latched at start
//   busy / done         high while running or draining / one-cycle end pulse
//   found_valid/ready/nonce  valid-ready read port of the found-nonce FIFO
//   mining_yield        accumulated reward (saturating, persists across runs)
//   overflow            sticky: a hit was dropped because the FIFO was full

// Per-lane hash pipeline: stage 0 holds the issued nonce, and stage 1 holds its hash.
// The hit is evaluated combinationally from stage 1 and consumed by the top level
// on the following (stage-2) edge.
module trinity_v5_lane #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_vld,
    input  logic [NONCE_W-1:0] issue_nonce,
    input  logic [31:0]        header,
    input  logic [31:0]        target,
    output logic               hit,
    output logic [NONCE_W-1:0] nonce
);
    logic [1:0]         vld_pipe;
    logic [NONCE_W-1:0] nonce0, nonce1;
    logic [31:0]        hash1, h_mul, hash_d;

    always_comb begin
        h_mul  = (header ^ 32'(nonce0)) * 32'h9E37_79B9;
        hash_d = h_mul ^ (h_mul >> 15);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            nonce0   <= '0;
            nonce1   <= '0;
            hash1    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue_vld};
            nonce0   <= issue_nonce;
            nonce1   <= nonce0;
            hash1    <= hash_d;
        end
    end

    assign hit   = vld_pipe[1] && (hash1 <= target);
    assign nonce = nonce1;
endmodule

module trinity_v5_miner #(
    parameter int          LANES      = 4,
    parameter int          NONCE_W    = 32,
    parameter int          YIELD_W    = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned REWARD     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        header,
    input  logic [31:0]        target,
    input  logic [NONCE_W-1:0] nonce_limit,
    output logic               busy,
    output logic               done,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [YIELD_W-1:0] mining_yield,
    output logic               overflow
);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough that REWARD * LANES added to a full counter cannot wrap.
    localparam int SUM_W = YIELD_W + 40;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [NONCE_W-1:0] base, lim_q;
    logic [31:0]        hdr_q, tgt_q;
    logic               drain_cnt;
    logic               last_issue;

    logic [LANES-1:0]              issue_vld, hit;
    logic [LANES-1:0][NONCE_W-1:0] issue_nonce, hit_nonce;

    // Compare in NONCE_W+1 bits so that a limit near the top of the range
    // cannot wrap base+LANES back below the limit.
    assign last_issue = ({1'b0, base} + (NONCE_W+1)'(LANES)) > {1'b0, lim_q};

    // ---------------- lanes ----------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign issue_nonce[i] = base + NONCE_W'(i);
        assign issue_vld[i]   = (state == RUN) &&
                                (({1'b0, base} + (NONCE_W+1)'(i)) <= {1'b0, lim_q});

        trinity_v5_lane #(.NONCE_W(NONCE_W)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .issue_vld   (issue_vld[i]),
            .issue_nonce (issue_nonce[i]),
            .header      (hdr_q),
            .target      (tgt_q),
            .hit         (hit[i]),
            .nonce       (hit_nonce[i])
        );
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            lim_q     <= '0;
            hdr_q     <= '0;
            tgt_q     <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        base  <= '0;
                        hdr_q <= header;
                        tgt_q <= target;
                        lim_q <= nonce_limit;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    base <= base + NONCE_W'(LANES);
                    if (last_issue) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                // Two edges: just long enough to retire the final issue group.
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- stage 2: hit reduction ----------------
    logic [CNT_W-1:0]   hit_cnt;
    logic [NONCE_W-1:0] first_nonce;
    logic               any_hit;

    // Scan from the top down so the lowest hitting lane is the last to be written.
    always_comb begin
        hit_cnt     = '0;
        any_hit     = 1'b0;
        first_nonce = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_cnt     = hit_cnt + CNT_W'(1);
                any_hit     = 1'b1;
                first_nonce = hit_nonce[i];
            end
        end
    end

    logic [SUM_W-1:0] yield_sum;
    assign yield_sum = SUM_W'(mining_yield) + SUM_W'(REWARD) * SUM_W'(hit_cnt);

    // ---------------- found-nonce FIFO ----------------
    logic [NONCE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        fcnt;
    logic               full, pop, push_ok;

    assign full        = (fcnt == (AW+1)'(FIFO_DEPTH));
    assign found_valid = (fcnt != '0);
    assign pop         = found_valid & found_ready;
    // A simultaneous pop frees a slot before the push lands.
    assign push_ok     = any_hit & (~full | pop);
    assign found_nonce = found_valid ? mem[rd_ptr] : '0;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= first_nonce;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fcnt         <= '0;
            overflow     <= 1'b0;
            mining_yield <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop})
                2'b10:   fcnt <= fcnt + (AW+1)'(1);
                2'b01:   fcnt <= fcnt - (AW+1)'(1);
                default: fcnt <= fcnt;
            endcase
            if (any_hit && full && !pop) overflow <= 1'b1;
            if (any_hit) begin
                if (yield_sum > SUM_W'({YIELD_W{1'b1}}))
                    mining_yield <= '1;
                else
                    mining_yield <= yield_sum[YIELD_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_trinity_v5_miner.sv
module tb_trinity_v5_miner;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, found_ready;
    logic [31:0] header, target, nonce_limit;
    logic        busy, done, found_valid, overflow;
    logic [31:0] found_nonce, mining_yield;

    // narrow-yield instance for the saturation case
    logic        s_start;
    logic [31:0] s_header, s_target, s_limit;
    logic        s_busy, s_done, s_fv, s_ovf;
    logic [31:0] s_fn;
    logic [3:0]  s_yield;

    always #5 clk = ~clk;

    trinity_v5_miner dut (
        .clk(clk), .rst(rst), .start(start), .header(header), .target(target),
        .nonce_limit(nonce_limit), .busy(busy), .done(done),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .mining_yield(mining_yield), .overflow(overflow)
    );

    trinity_v5_miner #(.YIELD_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .header(s_header), .target(s_target),
        .nonce_limit(s_limit), .busy(s_busy), .done(s_done),
        .found_valid(s_fv), .found_ready(1'b1),
        .found_nonce(s_fn), .mining_yield(s_yield), .overflow(s_ovf)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_yield;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] tgt;
        logic [31:0] lim;
        bit          rdy;
        int          exp_hits;
        int          exp_busy;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mhash(input logic [31:0] hd, input logic [31:0] n);
        logic [31:0] h;
        h = (hd ^ n) * 32'h9E37_79B9;
        return h ^ (h >> 15);
    endfunction

    // Reference sweep: returns the hit count, and optionally queues the
    // lowest hitting nonce of each 4-wide group as an expected FIFO entry.
    function automatic int model(input logic [31:0] hd, tg, lim, input bit push_q);
        int hits = 0;
        for (longint b = 0; b <= longint'(lim); b += 4) begin
            bit first = 1'b1;
            for (int l = 0; l < 4; l++) begin
                longint n = b + l;
                if (n <= longint'(lim) && mhash(hd, n[31:0]) <= tg) begin
                    hits++;
                    if (first && push_q) exp_q.push_back(n[31:0]);
                    first = 1'b0;
                end
            end
        end
        return hits;
    endfunction

    // scoreboard: each observed pop is compared with the oldest expected entry
    always @(negedge clk) begin
        if (found_valid && found_ready) begin
            if (exp_q.size() == 0) chk(1'b0, "sb_unexpected_pop", found_nonce, 0);
            else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk(found_nonce == e, "sb_found_nonce", found_nonce, e);
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({busy, done, found_valid, overflow} == 4'b0, {nm, "_flags"},
            {busy, done, found_valid, overflow}, 0);
        chk(mining_yield == 0, {nm, "_yield"}, mining_yield, 0);
        chk(found_nonce == 0, {nm, "_nonce"}, found_nonce, 0);
    endtask

    task automatic do_run(input logic [31:0] hd, tg, lim, input bit rdy, input int exp_busy,
                          input string nm);
        int  busy_n = 0;
        bit  seen   = 1'b0;
        int  c      = 0;
        @(posedge clk); #1;
        header = hd; target = tg; nonce_limit = lim; found_ready = rdy; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (c < 300 && !seen) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
            c++;
        end
        chk(seen, {nm, "_done_seen"}, seen, 1);
        chk(busy_n == exp_busy, {nm, "_busy_cycles"}, busy_n, exp_busy);
        chk(!busy, {nm, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk(!done && !busy, {nm, "_done_one_cycle"}, {done, busy}, 0);
    endtask

    task automatic drain(input string nm);
        int c = 0;
        @(posedge clk); #1;
        found_ready = 1'b1;
        @(negedge clk);
        while (c < 50 && found_valid) begin
            @(negedge clk);
            c++;
        end
        chk(!found_valid, {nm, "_fifo_empty"}, found_valid, 0);
        chk(exp_q.size() == 0, {nm, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; found_ready = 1'b0;
        header = '0; target = '0; nonce_limit = '0;
        s_start = 1'b0; s_header = '0; s_target = '0; s_limit = '0;
        exp_yield = '0;

        tbl[0] = '{32'h0000_0005, 32'h0000_0000, 32'd15, 1'b1, 1,  6};
        tbl[1] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'd13, 1'b1, 14, 6};
        tbl[2] = '{32'hDEAD_BEEF, 32'h2000_0000, 32'd63, 1'b1, 0,  18};
        tbl[3] = '{32'hA5A5_A5A5, 32'h8000_0000, 32'd0,  1'b1, 0,  3};
        tbl[4] = '{32'h0BAD_F00D, 32'h4000_0000, 32'd4,  1'b1, 0,  4};
        for (int i = 2; i < 5; i++)
            tbl[i].exp_hits = model(tbl[i].hdr, tbl[i].tgt, tbl[i].lim, 1'b0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_zero("post_reset");
        end

        // table-driven runs, FIFO drained continuously
        for (int i = 0; i < 5; i++) begin
            exp_yield += 32'(tbl[i].exp_hits);
            void'(model(tbl[i].hdr, tbl[i].tgt, tbl[i].lim, 1'b1));
            do_run(tbl[i].hdr, tbl[i].tgt, tbl[i].lim, tbl[i].rdy, tbl[i].exp_busy, "vec");
            drain("vec");
            chk(mining_yield == exp_yield, "vec_yield", mining_yield, exp_yield);
            chk(!overflow, "vec_overflow", overflow, 0);
        end

        // single hit held in the FIFO
        exp_q.push_back(32'd5);
        exp_yield += 1;
        do_run(32'd5, 32'd0, 32'd15, 1'b0, 6, "single");
        chk(found_valid && found_nonce == 5, "single_head", found_nonce, 5);
        chk(mining_yield == exp_yield, "single_yield", mining_yield, exp_yield);
        drain("single");

        // fill FIFO exactly, then overflow on rerun
        found_ready = 1'b0;
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
        exp_yield += 16;
        do_run(32'h3, 32'hFFFF_FFFF, 32'd15, 1'b0, 6, "fill");
        chk(found_nonce == 0, "fill_head", found_nonce, 0);
        chk(mining_yield == exp_yield, "fill_yield", mining_yield, exp_yield);
        chk(!overflow, "fill_no_overflow", overflow, 0);
        exp_yield += 20;
        do_run(32'h3, 32'hFFFF_FFFF, 32'd19, 1'b0, 7, "ovf");
        chk(found_nonce == 0, "ovf_head", found_nonce, 0);
        chk(mining_yield == exp_yield, "ovf_yield", mining_yield, exp_yield);
        chk(overflow, "ovf_set", overflow, 1);
        drain("ovf");
        chk(overflow, "ovf_sticky", overflow, 1);

        // mid-run reset, with an ignored start during RUN
        @(posedge clk); #1;
        header = 32'd5; target = 32'd0; nonce_limit = 32'd15; found_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;           // edge S
        start = 1'b0;
        @(posedge clk); #1;           // S+1
        start = 1'b1;
        @(negedge clk);
        chk(busy, "midrst_busy", busy, 1);
        @(posedge clk); #1;           // S+2
        start = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        exp_yield = '0;
        @(negedge clk);
        chk_zero("midrst_in");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero("midrst_after");

        exp_q.push_back(32'd5);
        exp_yield = 1;
        do_run(32'd5, 32'd0, 32'd15, 1'b0, 6, "rerun");
        chk(found_valid && found_nonce == 5, "rerun_head", found_nonce, 5);
        chk(mining_yield == exp_yield, "rerun_yield", mining_yield, exp_yield);
        chk(!overflow, "rerun_overflow", overflow, 0);
        drain("rerun");

        // saturation on the 4-bit yield instance
        begin
            int c = 0;
            @(posedge clk); #1;
            s_header = 32'h77; s_target = 32'hFFFF_FFFF; s_limit = 32'd31; s_start = 1'b1;
            @(posedge clk); #1;
            s_start = 1'b0;
            @(negedge clk);
            while (c < 200 && !s_done) begin
                @(negedge clk);
                c++;
            end
            chk(s_done, "sat_done_seen", s_done, 1);
            chk(s_yield == 4'hF, "sat_yield", s_yield, 4'hF);
            repeat (3) @(negedge clk);
            chk(s_yield == 4'hF, "sat_yield_hold", s_yield, 4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
